// File: rtl/program_loader_pkg.sv
`default_nettype none
// ============================================================================
// Package  : definitions
// Purpose  : Shared byte and memory-control encodings for the loader and mem_unit.
// Revision : 1.0 - initial release
// ============================================================================
package definitions;

    typedef logic [7:0] BYTE;

    typedef enum logic [1:0] {
        MEM_NOP   = 2'd0,
        MEM_READ  = 2'd1,
        MEM_WRITE = 2'd2
    } MEM_OP;

    typedef enum logic [1:0] {
        MEM_FROM_ALU    = 2'd0,
        MEM_FROM_REG    = 2'd1,
        MEM_FROM_LOADER = 2'd2
    } MEM_SRC;

    typedef enum logic [1:0] {
        ADDR_FROM_PC     = 2'd0,
        ADDR_FROM_ALU    = 2'd1,
        ADDR_FROM_LOADER = 2'd2
    } MEM_ADDR;

endpackage
`default_nettype wire

// File: rtl/program_loader_if.sv
`default_nettype none
// ============================================================================
// Interface : program_loader_if
// Purpose   : Valid/ready program byte stream into the loader.
// Revision  : 1.0 - initial release
// ============================================================================
interface program_loader_if;
    import definitions::*;

    BYTE  in_data;
    logic in_valid;
    logic in_last;
    logic in_ready;

    modport master (output in_data, output in_valid, output in_last, input in_ready);
    modport slave  (input in_data, input in_valid, input in_last, output in_ready);

endinterface
`default_nettype wire

// File: rtl/program_loader.sv
`default_nettype none
// ============================================================================
// Module   : program_loader
// Purpose  : Streams program bytes into consecutive memory addresses via mem_unit.
//            Optional trailing checksum byte when LOADER_CHECKSUM_EN is defined.
// Revision : 1.0 - initial release
// ============================================================================
module program_loader
    import definitions::*;
#(
    parameter int ADDR_W = 8
) (
    input  wire logic              clk,
    input  wire logic              reset,
    input  wire logic              start,
    input  wire logic [ADDR_W-1:0] base_addr,
    program_loader_if.slave        in_if,
    output BYTE                    loader_out,
    output logic [ADDR_W-1:0]      loader_addr,
    output MEM_OP                  mem_op,
    output MEM_SRC                 mem_src,
    output MEM_ADDR                mem_addr,
    output logic                   busy,
    output logic                   done,
    output logic                   err,
    output logic [ADDR_W:0]        load_count,
    output BYTE                    loader_sum
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_LOAD  = 2'd1,
`ifdef LOADER_CHECKSUM_EN
        S_CHECK = 2'd3,
`endif
        S_FAIL  = 2'd2
    } state_t;

    state_t            state_q;
    logic [ADDR_W-1:0] cnt_q;
    logic [ADDR_W-1:0] cnt_d;
    logic [ADDR_W-1:0] addr_q;
    BYTE               data_q;
    MEM_OP             op_q;
    logic              done_q;
    logic              err_q;
    logic [ADDR_W:0]   count_q;
    logic              ready;
    logic              at_max;

    // The counter saturates at the top address so it can never wrap onto low memory.
    assign at_max = (cnt_q == {ADDR_W{1'b1}});
    assign cnt_d  = at_max ? cnt_q : cnt_q + 1'b1;

`ifdef LOADER_CHECKSUM_EN
    BYTE sum_q;
    BYTE sum_d;
    assign sum_d = sum_q + in_if.in_data;
    assign ready = (state_q == S_LOAD) || (state_q == S_CHECK);
`else
    assign ready = (state_q == S_LOAD);
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            addr_q  <= '0;
            data_q  <= '0;
            op_q    <= MEM_NOP;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
            count_q <= '0;
`ifdef LOADER_CHECKSUM_EN
            sum_q   <= '0;
`endif
        end else begin
            op_q <= MEM_NOP;
            case (state_q)
                S_IDLE: begin
                    if (start) begin
                        cnt_q   <= base_addr;
                        count_q <= '0;
                        done_q  <= 1'b0;
                        err_q   <= 1'b0;
`ifdef LOADER_CHECKSUM_EN
                        sum_q   <= '0;
`endif
                        state_q <= S_LOAD;
                    end
                end
                S_LOAD: begin
                    if (in_if.in_valid) begin
                        data_q  <= in_if.in_data;
                        addr_q  <= cnt_q;
                        op_q    <= MEM_WRITE;
                        count_q <= count_q + 1'b1;
                        cnt_q   <= cnt_d;
`ifdef LOADER_CHECKSUM_EN
                        sum_q   <= sum_d;
`endif
                        if (in_if.in_last) begin
`ifdef LOADER_CHECKSUM_EN
                            state_q <= S_CHECK;
`else
                            done_q  <= 1'b1;
                            state_q <= S_IDLE;
`endif
                        end else if (at_max) begin
                            state_q <= S_FAIL;
                        end
                    end
                end
`ifdef LOADER_CHECKSUM_EN
                // The check byte only settles the verdict; it is never written.
                S_CHECK: begin
                    if (in_if.in_valid) begin
                        if (sum_d == 8'd0) begin
                            done_q  <= 1'b1;
                            state_q <= S_IDLE;
                        end else begin
                            state_q <= S_FAIL;
                        end
                    end
                end
`endif
                S_FAIL: begin
                    err_q   <= 1'b1;
                    state_q <= S_IDLE;
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign in_if.in_ready = ready;
    assign loader_out     = data_q;
    assign loader_addr    = addr_q;
    assign mem_op         = op_q;
    assign mem_src        = MEM_FROM_LOADER;
    assign mem_addr       = ADDR_FROM_LOADER;
    assign busy           = (state_q != S_IDLE);
    assign done           = done_q;
    assign err            = err_q;
    assign load_count     = count_q;
`ifdef LOADER_CHECKSUM_EN
    assign loader_sum     = sum_q;
`else
    assign loader_sum     = '0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_program_loader.sv
`default_nettype none
// ============================================================================
// Module   : tb_program_loader
// Purpose  : Directed self-checking bench for program_loader (LOADER_CHECKSUM_EN aware).
// Revision : 1.0 - initial release
// ============================================================================
module tb_program_loader;
    import definitions::*;

    logic       clk = 1'b0;
    logic       reset;
    logic       start;
    logic [7:0] base_addr;
    BYTE        loader_out;
    logic [7:0] loader_addr;
    MEM_OP      mem_op;
    MEM_SRC     mem_src;
    MEM_ADDR    mem_addr;
    logic       busy, done, err;
    logic [8:0] load_count;
    BYTE        loader_sum;

    int nvec = 0;
    int nerr = 0;

    program_loader_if lif();

    program_loader #(.ADDR_W(8)) dut (
        .clk         (clk),
        .reset       (reset),
        .start       (start),
        .base_addr   (base_addr),
        .in_if       (lif.slave),
        .loader_out  (loader_out),
        .loader_addr (loader_addr),
        .mem_op      (mem_op),
        .mem_src     (mem_src),
        .mem_addr    (mem_addr),
        .busy        (busy),
        .done        (done),
        .err         (err),
        .load_count  (load_count),
        .loader_sum  (loader_sum)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nvec++;
        assert (obs === exp) else begin
            nerr++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic start_load(input logic [7:0] base);
        start     = 1'b1;
        base_addr = base;
        tick();
        start     = 1'b0;
    endtask

    task automatic beat(input logic [7:0] d, input logic last);
        lif.in_valid = 1'b1;
        lif.in_data  = d;
        lif.in_last  = last;
        tick();
        lif.in_valid = 1'b0;
        lif.in_last  = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1; start = 1'b0; base_addr = 8'h00;
        lif.in_valid = 1'b0; lif.in_data = 8'h00; lif.in_last = 1'b0;
        tick(); tick();
        check("rst_ready", 32'(lif.in_ready), 0);
        check("rst_busy",  32'(busy), 0);
        check("rst_done",  32'(done), 0);
        check("rst_err",   32'(err), 0);
        check("rst_data",  32'(loader_out), 0);
        check("rst_addr",  32'(loader_addr), 0);
        check("rst_count", 32'(load_count), 0);
        check("rst_sum",   32'(loader_sum), 0);
        check("rst_op",    32'(mem_op), 32'(MEM_NOP));
        check("src_const", 32'(mem_src), 32'(MEM_FROM_LOADER));
        check("adr_const", 32'(mem_addr), 32'(ADDR_FROM_LOADER));
        reset = 1'b0;
        tick();

`ifndef LOADER_CHECKSUM_EN
        // Back-to-back stream at 0x10
        start_load(8'h10);
        check("s1_ready", 32'(lif.in_ready), 1);
        check("s1_busy",  32'(busy), 1);
        beat(8'hA0, 1'b0);
        check("s1_op0",   32'(mem_op), 32'(MEM_WRITE));
        check("s1_adr0",  32'(loader_addr), 32'h10);
        check("s1_dat0",  32'(loader_out), 32'hA0);
        beat(8'hA1, 1'b0);
        check("s1_op1",   32'(mem_op), 32'(MEM_WRITE));
        check("s1_adr1",  32'(loader_addr), 32'h11);
        beat(8'hA2, 1'b1);
        check("s1_op2",   32'(mem_op), 32'(MEM_WRITE));
        check("s1_adr2",  32'(loader_addr), 32'h12);
        check("s1_dat2",  32'(loader_out), 32'hA2);
        check("s1_count", 32'(load_count), 3);
        check("s1_done",  32'(done), 1);
        check("s1_busy0", 32'(busy), 0);
        check("s1_rdy0",  32'(lif.in_ready), 0);
        tick();
        check("s1_opnop", 32'(mem_op), 32'(MEM_NOP));

        // Gapped stream: writes only after beats, contiguous addresses
        start_load(8'h10);
        check("s2_donecl", 32'(done), 0);
        for (int i = 0; i < 3; i++) begin
            beat(8'hA0 + 8'(i), (i == 2));
            check("s2_opw",  32'(mem_op), 32'(MEM_WRITE));
            check("s2_adr",  32'(loader_addr), 32'h10 + i);
            tick();
            check("s2_opn",  32'(mem_op), 32'(MEM_NOP));
        end
        check("s2_done",  32'(done), 1);
        check("s2_count", 32'(load_count), 3);

        // Overflow at top of memory
        start_load(8'hFE);
        beat(8'hB0, 1'b0);
        check("s3_adr0",  32'(loader_addr), 32'hFE);
        beat(8'hB1, 1'b0);
        check("s3_adr1",  32'(loader_addr), 32'hFF);
        check("s3_op1",   32'(mem_op), 32'(MEM_WRITE));
        check("s3_rdy",   32'(lif.in_ready), 0);
        check("s3_busy",  32'(busy), 1);
        lif.in_valid = 1'b1; lif.in_data = 8'hB2; lif.in_last = 1'b1;
        tick();
        check("s3_err",   32'(err), 1);
        check("s3_done",  32'(done), 0);
        check("s3_busy0", 32'(busy), 0);
        check("s3_op2",   32'(mem_op), 32'(MEM_NOP));
        check("s3_count", 32'(load_count), 2);
        check("s3_data",  32'(loader_out), 32'hB1);
        tick();
        check("s3_op3",   32'(mem_op), 32'(MEM_NOP));
        lif.in_valid = 1'b0; lif.in_last = 1'b0;

        // Asynchronous reset mid-load
        start_load(8'h20);
        check("s4_errcl", 32'(err), 0);
        beat(8'hD0, 1'b0);
        beat(8'hD1, 1'b0);
        lif.in_valid = 1'b1; lif.in_data = 8'hD2;
        reset = 1'b1;
        #1;
        check("s4_busy",  32'(busy), 0);
        check("s4_rdy",   32'(lif.in_ready), 0);
        check("s4_data",  32'(loader_out), 0);
        check("s4_addr",  32'(loader_addr), 0);
        check("s4_count", 32'(load_count), 0);
        check("s4_op",    32'(mem_op), 32'(MEM_NOP));
        lif.in_valid = 1'b0;
        tick();
        reset = 1'b0;
        tick();
        start_load(8'h30);
        beat(8'hE0, 1'b1);
        check("s4_radr",  32'(loader_addr), 32'h30);
        check("s4_rdat",  32'(loader_out), 32'hE0);
        check("s4_rdone", 32'(done), 1);
        check("s4_rcnt",  32'(load_count), 1);

        // start during LOAD is ignored
        start_load(8'h40);
        beat(8'hC0, 1'b0);
        start = 1'b1; base_addr = 8'h80;
        beat(8'hC1, 1'b0);
        start = 1'b0;
        check("s5_adr1",  32'(loader_addr), 32'h41);
        beat(8'hC2, 1'b1);
        check("s5_adr2",  32'(loader_addr), 32'h42);
        check("s5_done",  32'(done), 1);
        check("s5_count", 32'(load_count), 3);
`else
        // Good checksum: 01+02+03+FA = 0x100
        start_load(8'h50);
        beat(8'h01, 1'b0);
        beat(8'h02, 1'b0);
        beat(8'h03, 1'b1);
        check("c1_op",    32'(mem_op), 32'(MEM_WRITE));
        check("c1_adr",   32'(loader_addr), 32'h52);
        check("c1_sum",   32'(loader_sum), 32'h06);
        check("c1_busy",  32'(busy), 1);
        check("c1_rdy",   32'(lif.in_ready), 1);
        beat(8'hFA, 1'b0);
        check("c1_opnop", 32'(mem_op), 32'(MEM_NOP));
        check("c1_done",  32'(done), 1);
        check("c1_busy0", 32'(busy), 0);
        check("c1_count", 32'(load_count), 3);

        // Bad checksum
        start_load(8'h60);
        check("c2_donecl", 32'(done), 0);
        check("c2_sumcl",  32'(loader_sum), 0);
        beat(8'h01, 1'b0);
        beat(8'h02, 1'b0);
        beat(8'h03, 1'b1);
        beat(8'hFB, 1'b0);
        check("c2_opnop", 32'(mem_op), 32'(MEM_NOP));
        check("c2_adr",   32'(loader_addr), 32'h62);
        check("c2_data",  32'(loader_out), 32'h03);
        check("c2_busy",  32'(busy), 1);
        tick();
        check("c2_err",   32'(err), 1);
        check("c2_done",  32'(done), 0);
        check("c2_busy0", 32'(busy), 0);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/program_loader.md
# program_loader

Sequential byte-stream loader that sits directly upstream of `mem_unit` and is the sole producer of its `loader_out` data source. On a start pulse it accepts program bytes over a valid/ready stream and writes them to consecutive addresses from a base address. For each accepted byte it issues one `MEM_WRITE` with `MEM_FROM_LOADER` / `ADDR_FROM_LOADER` on the following cycle. Status flags let the controller hold the core until the load finishes.

## Interface
- `ADDR_W`, default 8: memory address width; capacity is 2^ADDR_W bytes.
- `clk`  in  1  system clock; all state updates on rising edge.
- `reset`  in  1  asynchronous, active-high; clears all state immediately.
- `start`  in  1  one-cycle pulse; begins a load; honoured only in IDLE.
- `base_addr`  in  ADDR_W  first write address; latched on accepted `start`.
- `in_data`  in  8 (BYTE)  stream byte.
- `in_valid`  in  1  `in_data` and `in_last` are valid.
- `in_last`  in  1  marks the final program byte.
- `in_ready`  out  1  loader can accept a byte this cycle.
- `loader_out`  out  8 (BYTE)  registered write data, feeds `mem_unit.loader_out`.
- `loader_addr`  out  ADDR_W  registered write address.
- `mem_op`  out  MEM_OP  `MEM_WRITE` for exactly one cycle per accepted byte, otherwise `MEM_NOP`.
- `mem_src`  out  MEM_SRC  constant `MEM_FROM_LOADER`.
- `mem_addr`  out  MEM_ADDR  constant `ADDR_FROM_LOADER`.
- `busy`  out  1  high in any state other than IDLE.
- `done`  out  1  level; the last load succeeded; cleared by `start`.
- `err`  out  1  level; the last load failed; cleared by `start`.
- `load_count`  out  ADDR_W+1  bytes written in the current or last load.
- `loader_sum`  out  8  running checksum (macro only; tied to 0 otherwise).

## Operation
- FSM states: IDLE, LOAD, CHECK (macro only), FAIL.
- **IDLE:** `in_ready`=0. A `start` pulse latches `base_addr` into the address counter, clears `load_count`, `loader_sum`, `done` and `err`, then moves to LOAD.
- **LOAD:** `in_ready`=1. A beat is `in_valid && in_ready`. On each beat:
  - `loader_out` ← `in_data` and `loader_addr` ← counter.
  - `mem_op` = `MEM_WRITE` on the next cycle.
  - The counter and `load_count` increment.
- Beat with `in_last`:
  - macro on → CHECK;
  - macro off → IDLE with `done`=1.
- Overflow: a beat at counter = 2^ADDR_W−1 without `in_last` still writes that byte, then moves to FAIL. The counter never wraps.
- **FAIL:** sets `err`=1 and returns to IDLE next cycle. Remaining stream bytes are not accepted.
- `start` while busy is ignored.
- `start` and `in_valid` in the same IDLE cycle: the byte is not accepted.
- Reset mid-load aborts immediately. Memory already written is left as is.

## Timing
- Reset values:
  - `in_ready`, `busy`, `done`, `err` = 0.
  - `loader_out`, `loader_addr`, `load_count`, `loader_sum` = 0.
  - `mem_op` = `MEM_NOP`.
  - FSM in IDLE.
- `start` at edge N → LOAD and `in_ready`=1 from cycle N+1.
- A beat at edge N → write presented during cycle N+1 and committed by `mem_unit` at edge N+2.
- Throughput is 1 byte/cycle; there are no bubbles while `in_valid` stays high.
- `done` and `busy` update on the same edge as the final transition. The last `MEM_WRITE` is still presented in the cycle `busy` falls, so the controller must wait one more cycle before issuing memory ops.

## Configuration
- `LOADER_CHECKSUM_EN` defined:
  - `loader_sum` accumulates the mod-256 sum of the data bytes.
  - After the `in_last` beat, CHECK accepts one extra byte, which is not written to memory.
  - If `loader_sum` + that byte ≡ 0 mod 256 → IDLE with `done`=1; otherwise FAIL.
- `LOADER_CHECKSUM_EN` undefined: no CHECK state, `loader_sum` tied to 0, `in_last` ends the load.

## Structure
- Package `definitions` holds `BYTE`, `MEM_OP` (including `MEM_NOP`), `MEM_SRC` (`MEM_FROM_LOADER`) and `MEM_ADDR` (`ADDR_FROM_LOADER`).
- The loader state enum is local to the module.
- Single module; no sub-module is warranted.

## Test plan
- Reset, then `start` with `base_addr`=0x10 and stream A0,A1,A2 (A2 `in_last`) back-to-back:
  - `MEM_WRITE` on three consecutive cycles at 0x10/0x11/0x12;
  - `load_count`=3, `done`=1, `busy`=0.
- Same stream with `in_valid` gapped every other cycle → writes occur only after beats; addresses stay contiguous.
- `base_addr`=0xFE, stream of 3 bytes, none `in_last` until the third:
  - writes at 0xFE and 0xFF, then `err`=1;
  - the third byte is never accepted.
- Assert `reset` after 2 of 5 bytes → all outputs return to reset values immediately; a following `start` reloads cleanly.
- `start` pulsed during LOAD → ignored (no address relatch).
- Macro on, data 01,02,03 then check byte FA → `done`=1. Repeat with FB → `err`=1, and the check byte is never written.
